inst_fetch_ctrl: RTL and testbench

Sequencer and arbiter for the word-addressed instruction ROM. Owns the program counter and drives the ROM address. Captures returned words into a valid/ready output register for the decode stage. Shares the single ROM read port with a debug/loader read port, using a starvation-bounded arbitration rule.

---
 rtl/inst_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// inst_fetch_ctrl : PC sequencer and fetch/debug arbiter for the ROM port  (rev 1.0)
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_data,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_DBG   = 2'd2
  } state_t;

  localparam logic [31:0] PC_INIT    = {RESET_PC[31:2], 2'b00};
  localparam logic [3:0]  STARVE_MAX = STARVE_LIMIT[3:0];

  state_t      state, state_nxt;
  state_t      ret_state, ret_nxt;
  logic [31:0] pc, pc_nxt;
  logic        valid_nxt;
  logic [31:0] data_nxt, ipc_nxt;
  logic [31:0] dbg_data_q, dbg_data_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        stalled;
  logic        unused_bits;

  assign unused_bits = ^{dbg_addr[1:0], redirect_pc[1:0]};
  assign stalled     = inst_valid & ~inst_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_HALT;
      ret_state  <= S_HALT;
      pc         <= PC_INIT;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      dbg_data_q <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      ret_state  <= ret_nxt;
      pc         <= pc_nxt;
      inst_valid <= valid_nxt;
      inst_data  <= data_nxt;
      inst_pc    <= ipc_nxt;
      dbg_data_q <= dbg_data_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ret_nxt      = ret_state;
    pc_nxt       = pc;
    // An accepted handshake always empties the output register unless refilled below.
    valid_nxt    = inst_valid & ~inst_ready;
    data_nxt     = inst_data;
    ipc_nxt      = inst_pc;
    dbg_data_nxt = dbg_data_q;
    starve_nxt   = dbg_req ? starve_cnt : 4'd0;

    case (state)
      S_HALT: begin
        if (dbg_req) begin
          state_nxt = S_DBG;
          ret_nxt   = S_HALT;
        end else if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = PC_INIT;
          valid_nxt = 1'b0;
        end
      end
      S_FETCH: begin
        if (halt_req) begin
          state_nxt = S_HALT;
          valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          pc_nxt    = {redirect_pc[31:2], 2'b00};
          valid_nxt = 1'b0;
        end else if (dbg_req && (stalled || starve_cnt == STARVE_MAX)) begin
          state_nxt = S_DBG;
          ret_nxt   = S_FETCH;
        end else if (!stalled) begin
          data_nxt  = rom_data;
          ipc_nxt   = pc;
          valid_nxt = 1'b1;
          pc_nxt    = pc + 32'd4;
          if (dbg_req && starve_cnt != STARVE_MAX)
            starve_nxt = starve_cnt + 4'd1;
        end
      end
      S_DBG: begin
        state_nxt    = ret_state;
        dbg_data_nxt = rom_data;
        starve_nxt   = 4'd0;
        if (redirect_valid) begin
          pc_nxt    = {redirect_pc[31:2], 2'b00};
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

  // Ack and read data are visible in the DBG cycle itself so the requester can drop dbg_req in time.
  assign dbg_ack  = (state == S_DBG);
  assign dbg_data = dbg_ack ? rom_data : dbg_data_q;
  assign rom_addr = dbg_ack ? {dbg_addr[31:2], 2'b00} : pc;
  assign halted   = (state == S_HALT) || (dbg_ack && ret_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl : scoreboard bench for inst_fetch_ctrl  (rev 1.0)
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_addr = '0;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic        halted;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  inst_fetch_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .STARVE_LIMIT(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .halt_req      (halt_req),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .dbg_req       (dbg_req),
    .dbg_addr      (dbg_addr),
    .dbg_ack       (dbg_ack),
    .dbg_data      (dbg_data),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return 32'hC0DE_0000 + {2'b00, a[31:2]};
  endfunction

  always_comb rom_data = rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_halt(input string tag);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},  {31'd0, inst_valid}, 32'd0);
    check({tag, "_data"},   inst_data, 32'd0);
    check({tag, "_ipc"},    inst_pc, 32'd0);
    check({tag, "_ack"},    {31'd0, dbg_ack}, 32'd0);
    check({tag, "_dbgd"},   dbg_data, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    check({tag, "_addr"},   rom_addr, 32'd0);
  endtask

  // Every accepted instruction is popped against the expected fetch order.
  always @(negedge clock) begin
    if (reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", inst_pc, 32'hFFFF_FFFF);
      end else begin : pop_blk
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", inst_pc, e);
        check("sb_data", inst_data, rom_fn(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b1;
    tick();

    // Streaming fetch from RESET_PC
    push_seq(32'h0, 4);
    inst_ready = 1'b1;
    do_start();
    check("first_cyc_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("first_valid", {31'd0, inst_valid}, 32'd1);
    check("run_halted", {31'd0, halted}, 32'd0);
    check("pc0", inst_pc, 32'h0);
    tick(); check("pc4", inst_pc, 32'h4);
    tick(); check("pc8", inst_pc, 32'h8);
    tick(); check("pcC", inst_pc, 32'hC);
    do_halt("strm");
    check("halt_valid", {31'd0, inst_valid}, 32'd0);
    check("halt_pc_kept", rom_addr, 32'h10);

    // Output stall
    push_seq(32'h0, 3);
    do_start();
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ipc", inst_pc, 32'h0);
      check("stall_data", inst_data, rom_fn(32'h0));
      check("stall_pc", rom_addr, 32'h4);
    end
    inst_ready = 1'b1;
    tick(); check("rel_pc4", inst_pc, 32'h4);
    tick(); check("rel_pc8", inst_pc, 32'h8);
    do_halt("stall");

    // Redirect while streaming
    push_seq(32'h0, 2);
    push_seq(32'h20, 2);
    do_start();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0022;
    tick();
    redirect_valid = 1'b0;
    check("redir_bubble", {31'd0, inst_valid}, 32'd0);
    check("redir_addr", rom_addr, 32'h20);
    tick(); check("redir_pc20", inst_pc, 32'h20);
    tick(); check("redir_pc24", inst_pc, 32'h24);
    do_halt("redir");

    // Starvation-forced debug grant during continuous fetch
    push_seq(32'h0, 7);
    do_start();
    tick();
    dbg_req  = 1'b1;
    dbg_addr = 32'h0000_0041;
    begin : starve_blk
      int n;
      n = 0;
      while (!dbg_ack && n < 20) begin
        tick();
        n++;
      end
      check("starve_cycles", 32'(n), 32'd5);
    end
    check("starve_ack", {31'd0, dbg_ack}, 32'd1);
    check("starve_addr", rom_addr, 32'h40);
    check("starve_dbgd", dbg_data, rom_fn(32'h40));
    dbg_req = 1'b0;
    tick();
    check("starve_ack_pulse", {31'd0, dbg_ack}, 32'd0);
    check("starve_dbgd_hold", dbg_data, rom_fn(32'h40));
    tick(); check("resume_pc14", inst_pc, 32'h14);
    tick(); check("resume_pc18", inst_pc, 32'h18);
    do_halt("starve");

    // Debug grant while output stalled
    push_seq(32'h0, 2);
    do_start();
    tick();
    inst_ready = 1'b0;
    dbg_req    = 1'b1;
    dbg_addr   = 32'h0000_0008;
    tick();
    check("stdbg_ack", {31'd0, dbg_ack}, 32'd1);
    check("stdbg_dbgd", dbg_data, rom_fn(32'h8));
    check("stdbg_idata", inst_data, rom_fn(32'h0));
    check("stdbg_valid", {31'd0, inst_valid}, 32'd1);
    dbg_req = 1'b0;
    tick();
    check("stdbg_ack_off", {31'd0, dbg_ack}, 32'd0);
    check("stdbg_ipc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick(); check("stdbg_pc4", inst_pc, 32'h4);
    do_halt("stdbg");

    // Debug read while halted
    dbg_req  = 1'b1;
    dbg_addr = 32'h0000_0046;
    tick();
    check("hdbg_ack", {31'd0, dbg_ack}, 32'd1);
    check("hdbg_halted", {31'd0, halted}, 32'd1);
    check("hdbg_dbgd", dbg_data, rom_fn(32'h44));
    dbg_req = 1'b0;
    tick();
    check("hdbg_ack_off", {31'd0, dbg_ack}, 32'd0);
    check("hdbg_halted2", {31'd0, halted}, 32'd1);
    check("hdbg_dbgd_hold", dbg_data, rom_fn(32'h44));

    // Asynchronous reset in the middle of a debug cycle
    inst_ready = 1'b0;
    do_start();
    tick();
    dbg_req  = 1'b1;
    dbg_addr = 32'h0000_0010;
    tick();
    check("mid_dbg_ack", {31'd0, dbg_ack}, 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_dbg");
    dbg_req = 1'b0;
    tick();
    tick();
    check("rst_dbg_noack", {31'd0, dbg_ack}, 32'd0);
    reset = 1'b1;

    // Asynchronous reset in the middle of a stream
    push_seq(32'h0, 1);
    inst_ready = 1'b1;
    do_start();
    tick();
    tick();
    #2 reset = 1'b0;
    #1 check_reset_vals("rst_strm");
    tick();
    reset = 1'b1;
    check("rst_strm_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Restart after reset refetches from RESET_PC
    push_seq(32'h0, 2);
    do_start();
    tick();
    check("refetch_valid", {31'd0, inst_valid}, 32'd1);
    check("refetch_pc0", inst_pc, 32'h0);
    tick();
    do_halt("refetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
